fp_mul_pipe: RTL and testbench

Parametrised, three-stage pipelined floating-point multiplier with valid/ready handshaking on both sides. It computes fp_Z = fp_X × fp_Y under one of five rounding modes and reports overflow/underflow. Exponent/mantissa widths are generic, and a tag travels with each operation. It is the next-generation multiplier core behind the team's fp_X/fp_Y/fp_Z/r_mode verification interface, adding backpressure, throughput of one operation per cycle, and width generalisation.

---
 rtl/fp_mul_pipe_if.sv | 33 +++
 rtl/fp_mul_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// The master side (producer/consumer) drives operands and out_ready; the core is the slave.
interface fp_mul_pipe_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       r_mode;
  logic [W-1:0]     fp_X;
  logic [W-1:0]     fp_Y;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     fp_Z;
  logic             ovrf;
  logic             udrf;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, r_mode, fp_X, fp_Y, in_tag, out_ready,
    input  in_ready, out_valid, fp_Z, ovrf, udrf, out_tag
  );

  modport slave (
    input  in_valid, r_mode, fp_X, fp_Y, in_tag, out_ready,
    output in_ready, out_valid, fp_Z, ovrf, udrf, out_tag
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier: input capture, classify/exponent, significand product,
// then normalise/round/pack. Global stall on output backpressure; subnormals flush to zero.
module fp_mul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  fp_mul_pipe_if.slave  bus
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned PW = 2 * MAN_W + 2;

  localparam logic signed [EW-1:0] Bias   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] ExpOvf = EW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     ExpOnes = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]     ExpMax  = {{(EXP_W-1){1'b1}}, 1'b0};

  localparam logic [2:0] RmRne = 3'd0;
  localparam logic [2:0] RmRz  = 3'd1;
  localparam logic [2:0] RmRdn = 3'd2;
  localparam logic [2:0] RmRup = 3'd3;
  localparam logic [2:0] RmRmm = 3'd4;

  typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} cls_e;

  logic w_advance;
  assign w_advance    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_advance && rst_n;

  // Input capture
  logic             r_in_valid;
  logic [W-1:0]     r_in_x;
  logic [W-1:0]     r_in_y;
  logic [2:0]       r_in_mode;
  logic [TAG_W-1:0] r_in_tag;

  // Stage 1: classify, sign, exponent sum
  logic [EXP_W-1:0]     w_ex, w_ey;
  logic [MAN_W-1:0]     w_fx, w_fy;
  logic                 w_x_zero, w_x_inf, w_x_nan;
  logic                 w_y_zero, w_y_inf, w_y_nan;
  cls_e                 w_s1_cls;
  logic signed [EW-1:0] w_s1_exp;
  logic [2:0]           w_s1_mode;

  always_comb begin
    w_ex     = r_in_x[W-2 -: EXP_W];
    w_ey     = r_in_y[W-2 -: EXP_W];
    w_fx     = r_in_x[MAN_W-1:0];
    w_fy     = r_in_y[MAN_W-1:0];
    // A zero exponent field covers both true zero and flushed subnormals.
    w_x_zero = (w_ex == '0);
    w_y_zero = (w_ey == '0);
    w_x_inf  = (w_ex == ExpOnes) && (w_fx == '0);
    w_y_inf  = (w_ey == ExpOnes) && (w_fy == '0);
    w_x_nan  = (w_ex == ExpOnes) && (w_fx != '0);
    w_y_nan  = (w_ey == ExpOnes) && (w_fy != '0);

    w_s1_cls = ClsNorm;
    if (w_x_nan || w_y_nan || (w_x_inf && w_y_zero) || (w_y_inf && w_x_zero)) begin
      w_s1_cls = ClsNan;
    end else if (w_x_inf || w_y_inf) begin
      w_s1_cls = ClsInf;
    end else if (w_x_zero || w_y_zero) begin
      w_s1_cls = ClsZero;
    end

    w_s1_exp  = EW'(w_ex) + EW'(w_ey) - Bias;
    w_s1_mode = (r_in_mode > RmRmm) ? RmRne : r_in_mode;
  end

  logic                 r_s1_valid;
  logic                 r_s1_sign;
  logic signed [EW-1:0] r_s1_exp;
  logic [MAN_W:0]       r_s1_mx;
  logic [MAN_W:0]       r_s1_my;
  cls_e                 r_s1_cls;
  logic [2:0]           r_s1_mode;
  logic [TAG_W-1:0]     r_s1_tag;

  // Stage 2: significand product
  logic [PW-1:0] w_prod;
  assign w_prod = PW'(r_s1_mx) * PW'(r_s1_my);

  logic                 r_s2_valid;
  logic                 r_s2_sign;
  logic signed [EW-1:0] r_s2_exp;
  logic [PW-1:0]        r_s2_prod;
  cls_e                 r_s2_cls;
  logic [2:0]           r_s2_mode;
  logic [TAG_W-1:0]     r_s2_tag;

  // Stage 3: normalise, round, range check, pack
  logic                 w_msb;
  logic [PW-2:0]        w_norm;
  logic [MAN_W-1:0]     w_frac;
  logic                 w_guard, w_sticky, w_inc;
  logic [MAN_W:0]       w_rnd;
  logic signed [EW-1:0] w_exp;
  logic [W-1:0]         w_z;
  logic                 w_ov, w_ud;

  always_comb begin
    w_msb    = r_s2_prod[PW-1];
    w_norm   = w_msb ? r_s2_prod[PW-2:0] : {r_s2_prod[PW-3:0], 1'b0};
    w_frac   = w_norm[PW-2 -: MAN_W];
    w_guard  = w_norm[MAN_W];
    w_sticky = |w_norm[MAN_W-1:0];

    case (r_s2_mode)
      RmRz:    w_inc = 1'b0;
      RmRdn:   w_inc = r_s2_sign && (w_guard || w_sticky);
      RmRup:   w_inc = !r_s2_sign && (w_guard || w_sticky);
      RmRmm:   w_inc = w_guard;
      default: w_inc = w_guard && (w_sticky || w_frac[0]);
    endcase

    // Carry-out means the significand rounded up to 2.0; the fraction field is then zero.
    w_rnd = {1'b0, w_frac} + (MAN_W + 1)'(w_inc);
    w_exp = r_s2_exp + EW'(w_msb) + EW'(w_rnd[MAN_W]);

    w_z  = '0;
    w_ov = 1'b0;
    w_ud = 1'b0;
    case (r_s2_cls)
      ClsNan:  w_z = {1'b0, ExpOnes, 1'b1, {(MAN_W-1){1'b0}}};
      ClsInf:  w_z = {r_s2_sign, ExpOnes, {MAN_W{1'b0}}};
      ClsZero: w_z = {r_s2_sign, {(W-1){1'b0}}};
      default: begin
        if (w_exp >= ExpOvf) begin
          w_ov = 1'b1;
          if ((r_s2_mode == RmRz) || (r_s2_mode == RmRup && r_s2_sign) ||
              (r_s2_mode == RmRdn && !r_s2_sign)) begin
            w_z = {r_s2_sign, ExpMax, {MAN_W{1'b1}}};
          end else begin
            w_z = {r_s2_sign, ExpOnes, {MAN_W{1'b0}}};
          end
        end else if (w_exp[EW-1] || (w_exp == '0)) begin
          w_ud = 1'b1;
          w_z  = {r_s2_sign, {(W-1){1'b0}}};
        end else begin
          w_z = {r_s2_sign, w_exp[EXP_W-1:0], w_rnd[MAN_W-1:0]};
        end
      end
    endcase
  end

  logic             r_out_valid;
  logic [W-1:0]     r_fp_z;
  logic             r_ovrf;
  logic             r_udrf;
  logic [TAG_W-1:0] r_out_tag;

  // Valid bits and visible outputs carry the reset; the datapath only needs advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_valid  <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_fp_z      <= '0;
      r_ovrf      <= 1'b0;
      r_udrf      <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_advance) begin
      r_in_valid  <= bus.in_valid;
      r_s1_valid  <= r_in_valid;
      r_s2_valid  <= r_s1_valid;
      r_out_valid <= r_s2_valid;
      r_fp_z      <= w_z;
      r_ovrf      <= w_ov;
      r_udrf      <= w_ud;
      r_out_tag   <= r_s2_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_in_x    <= bus.fp_X;
      r_in_y    <= bus.fp_Y;
      r_in_mode <= bus.r_mode;
      r_in_tag  <= bus.in_tag;

      r_s1_sign <= r_in_x[W-1] ^ r_in_y[W-1];
      r_s1_exp  <= w_s1_exp;
      r_s1_mx   <= {1'b1, w_fx};
      r_s1_my   <= {1'b1, w_fy};
      r_s1_cls  <= w_s1_cls;
      r_s1_mode <= w_s1_mode;
      r_s1_tag  <= r_in_tag;

      r_s2_sign <= r_s1_sign;
      r_s2_exp  <= r_s1_exp;
      r_s2_prod <= w_prod;
      r_s2_cls  <= r_s1_cls;
      r_s2_mode <= r_s1_mode;
      r_s2_tag  <= r_s1_tag;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.fp_Z      = r_fp_z;
  assign bus.ovrf      = r_ovrf;
  assign bus.udrf      = r_udrf;
  assign bus.out_tag   = r_out_tag;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe at default widths: directed cases plus randomized traffic
// checked against an integer-arithmetic reference model, with random output backpressure.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) bus ();

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] z;
    logic        ov;
    logic        ud;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  bit   presented = 0;
  bit   rnd_done = 0;
  logic [37:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Reference model: exact integer product, remainder-based rounding.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [2:0] m);
    exp_t r;
    logic s;
    int ex, ey, e, sh;
    logic [22:0] fx, fy;
    bit xz, yz, xi, yi, xn, yn, inc;
    longint unsigned p, q, rem, half;
    r.z = 32'h0; r.ov = 1'b0; r.ud = 1'b0; r.tag = 4'h0; r.acc = 0; r.lat = 0;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    fx = x[22:0]; fy = y[22:0];
    xz = (ex == 0); yz = (ey == 0);
    xi = (ex == 255) && (fx == 0); yi = (ey == 255) && (fy == 0);
    xn = (ex == 255) && (fx != 0); yn = (ey == 255) && (fy != 0);
    if (xn || yn || (xi && yz) || (yi && xz)) r.z = 32'h7FC00000;
    else if (xi || yi) r.z = {s, 8'hFF, 23'h0};
    else if (xz || yz) r.z = {s, 31'h0};
    else begin
      p = longint'({1'b1, fx}) * longint'({1'b1, fy});
      e = ex + ey - 127;
      if (p >= (64'd1 << 47)) begin sh = 24; e++; end
      else sh = 23;
      q = p >> sh;
      rem = p - (q << sh);
      half = 64'd1 << (sh - 1);
      case (m)
        3'd1:    inc = 0;
        3'd2:    inc = s && (rem != 0);
        3'd3:    inc = !s && (rem != 0);
        3'd4:    inc = (rem >= half);
        default: inc = (rem > half) || ((rem == half) && q[0]);
      endcase
      q = q + longint'(inc);
      if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e++; end
      if (e >= 255) begin
        r.ov = 1'b1;
        if ((m == 3'd1) || (m == 3'd3 && s) || (m == 3'd2 && !s)) r.z = {s, 8'hFE, 23'h7FFFFF};
        else r.z = {s, 8'hFF, 23'h0};
      end else if (e <= 0) begin
        r.ud = 1'b1;
        r.z = {s, 31'h0};
      end else begin
        r.z = {s, e[7:0], q[22:0]};
      end
    end
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                      input logic [3:0] t, input exp_t e);
    bus.in_valid = 1'b1; bus.fp_X = x; bus.fp_Y = y; bus.r_mode = m; bus.in_tag = t;
    e.tag = t;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.acc = cyc + 1;
        sbq.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic issue_e(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                         input logic [3:0] t, input logic [31:0] ez, input logic eo,
                         input logic eu, input bit lat);
    exp_t e;
    e.z = ez; e.ov = eo; e.ud = eu; e.tag = t; e.acc = 0; e.lat = lat;
    send(x, y, m, t, e);
  endtask

  task automatic issue_m(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                         input logic [3:0] t, input bit lat);
    exp_t e;
    e = model(x, y, m);
    e.lat = lat;
    send(x, y, m, t, e);
  endtask

  task automatic drain();
    for (int k = 0; k < 3000; k++) begin
      if (sbq.size() == 0 && !bus.out_valid) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(sbq.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    f = 23'($urandom);
    if ($urandom_range(0, 5) == 0) f = 23'h0;
    case ($urandom_range(0, 9))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(200, 254));
      3:       e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Monitor: compares each handed-off result and checks hold-stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    logic [37:0] cur;
    if (!rst_n) begin
      sbq.delete();
      presented = 0;
    end else if (bus.out_valid) begin
      cur = {bus.fp_Z, bus.ovrf, bus.udrf, bus.out_tag};
      if (sbq.size() == 0) begin
        chk("unexpected_output", 64'(cur), 64'd0);
        if (cur == 38'd0) begin
          n_pass--;
          $display("FAIL unexpected_output: got valid result, expected none");
        end
      end else begin
        e = sbq[0];
        if (!presented && e.lat) chk("latency", 64'(cyc - e.acc), 64'd3);
        if (presented) chk("stall_stable", 64'(cur), 64'(held));
        if (bus.out_ready) begin
          chk("fp_Z", 64'(bus.fp_Z), 64'(e.z));
          chk("flags", 64'({bus.ovrf, bus.udrf}), 64'({e.ov, e.ud}));
          chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
          void'(sbq.pop_front());
          presented = 0;
        end else begin
          presented = 1;
          held = cur;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.r_mode = 3'd0;
    bus.fp_X = 32'h0; bus.fp_Y = 32'h0; bus.in_tag = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_fp_Z", 64'(bus.fp_Z), 64'd0);
    chk("rst_flags", 64'({bus.ovrf, bus.udrf}), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue_e(32'h3FC00000, 32'h40000000, 3'd0, 4'd5, 32'h40400000, 1'b0, 1'b0, 1);
    drain();

    issue_e(32'h3F800001, 32'h3F800001, 3'd0, 4'd1, 32'h3F800002, 1'b0, 1'b0, 1);
    issue_e(32'h3F800001, 32'h3F800001, 3'd1, 4'd2, 32'h3F800002, 1'b0, 1'b0, 1);
    issue_e(32'h3F800001, 32'h3F800001, 3'd2, 4'd3, 32'h3F800002, 1'b0, 1'b0, 1);
    issue_e(32'h3F800001, 32'h3F800001, 3'd3, 4'd4, 32'h3F800003, 1'b0, 1'b0, 1);
    issue_e(32'h3F800001, 32'h3F800001, 3'd4, 4'd6, 32'h3F800002, 1'b0, 1'b0, 1);
    issue_e(32'h7F7FFFFF, 32'h40000000, 3'd0, 4'd7, 32'h7F800000, 1'b1, 1'b0, 1);
    issue_e(32'h7F7FFFFF, 32'h40000000, 3'd1, 4'd8, 32'h7F7FFFFF, 1'b1, 1'b0, 1);
    issue_e(32'hFF7FFFFF, 32'h40000000, 3'd3, 4'd9, 32'hFF7FFFFF, 1'b1, 1'b0, 1);
    issue_e(32'hFF7FFFFF, 32'h40000000, 3'd2, 4'd10, 32'hFF800000, 1'b1, 1'b0, 1);
    issue_e(32'h00800000, 32'h3F000000, 3'd0, 4'd11, 32'h00000000, 1'b0, 1'b1, 1);
    issue_e(32'h7F800000, 32'h00000000, 3'd0, 4'd12, 32'h7FC00000, 1'b0, 1'b0, 1);
    issue_e(32'h7FC00001, 32'h3F800000, 3'd0, 4'd13, 32'h7FC00000, 1'b0, 1'b0, 1);
    issue_e(32'hFF800000, 32'h40000000, 3'd6, 4'd14, 32'hFF800000, 1'b0, 1'b0, 1);
    issue_e(32'h80000000, 32'h40000000, 3'd0, 4'd15, 32'h80000000, 1'b0, 1'b0, 1);
    drain();

    // Backpressure: eight back-to-back beats with a mid-stream output stall.
    fork
      begin
        for (int i = 0; i < 8; i++) issue_m(rnd_op(), rnd_op(), 3'($urandom_range(0, 7)), 4'(i), 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: neither may emerge.
    issue_m(32'h40400000, 32'h40400000, 3'd0, 4'd1, 0);
    issue_m(32'h40A00000, 32'h3F000000, 3'd0, 4'd2, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk); #1;
    issue_e(32'h40000000, 32'h40400000, 3'd0, 4'd3, 32'h40C00000, 1'b0, 1'b0, 1);
    drain();

    // Random traffic with random idle gaps and random output backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          issue_m(rnd_op(), rnd_op(), 3'($urandom_range(0, 7)), 4'(i), 0);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
